// File: rtl/pattern_scanner_if.sv
// Bundle between the search FSM, the pattern scanner and its synchronous pattern RAM.
// The slave modport is the scanner; the master modport is the FSM/RAM side.
interface pattern_scanner_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              inc_flag;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic [ADDR_W-1:0] match_address;
    logic              found;
    logic              done_flag;

    modport slave (
        input  inc_flag,
        input  pattern,
        input  mask,
        input  mem_rdata,
        output mem_addr,
        output mem_ren,
        output match_address,
        output found,
        output done_flag
    );

    modport master (
        output inc_flag,
        output pattern,
        output mask,
        output mem_rdata,
        input  mem_addr,
        input  mem_ren,
        input  match_address,
        input  found,
        input  done_flag
    );
endinterface

// File: rtl/pattern_scanner.sv
// Walks pattern RAM from address 0 while inc_flag is high and reports the first word
// matching the masked pattern; one word every two cycles (fetch, then compare).
module pattern_scanner #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 511
) (
    input  logic                 clock,
    input  logic                 reset,
    pattern_scanner_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR_W = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_ren_reg, mem_ren_next;
    logic [ADDR_W-1:0] match_address_reg, match_address_next;
    logic              found_reg, found_next;
    logic              done_flag_reg, done_flag_next;

    // A bit agrees when it is masked out or when data and pattern bits are equal.
    logic [DATA_W-1:0] bit_ok;
    logic              hit;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit_cmp
            assign bit_ok[gi] = ~bus.mask[gi] | (bus.mem_rdata[gi] == bus.pattern[gi]);
        end
    endgenerate

    assign hit = &bit_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            mem_addr_reg      <= '0;
            mem_ren_reg       <= 1'b0;
            match_address_reg <= '0;
            found_reg         <= 1'b0;
            done_flag_reg     <= 1'b0;
        end else begin
            state_reg         <= state_next;
            mem_addr_reg      <= mem_addr_next;
            mem_ren_reg       <= mem_ren_next;
            match_address_reg <= match_address_next;
            found_reg         <= found_next;
            done_flag_reg     <= done_flag_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        mem_addr_next      = mem_addr_reg;
        mem_ren_next       = mem_ren_reg;
        match_address_next = match_address_reg;
        found_next         = found_reg;
        done_flag_next     = done_flag_reg;

        case (state_reg)
            IDLE: begin
                done_flag_next = 1'b0;
                mem_ren_next   = 1'b0;
                if (bus.inc_flag) begin
                    state_next         = FETCH;
                    mem_addr_next      = '0;
                    mem_ren_next       = 1'b1;
                    found_next         = 1'b0;
                    match_address_next = '0;
                end
            end
            FETCH: begin
                // Read enable is a single-cycle pulse whether or not the search continues.
                mem_ren_next = 1'b0;
                state_next   = bus.inc_flag ? CMP : IDLE;
            end
            CMP: begin
                // Abort wins over both hit and exhaustion.
                if (!bus.inc_flag) begin
                    state_next   = IDLE;
                    mem_ren_next = 1'b0;
                end else if (hit) begin
                    state_next         = DONE;
                    done_flag_next     = 1'b1;
                    found_next         = 1'b1;
                    match_address_next = mem_addr_reg;
                end else if (mem_addr_reg == LAST_ADDR_W) begin
                    state_next         = DONE;
                    done_flag_next     = 1'b1;
                    found_next         = 1'b0;
                    match_address_next = '0;
                end else begin
                    state_next    = FETCH;
                    mem_addr_next = mem_addr_reg + ADDR_ONE;
                    mem_ren_next  = 1'b1;
                end
            end
            DONE: begin
                if (!bus.inc_flag) begin
                    state_next     = IDLE;
                    done_flag_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                mem_ren_next   = 1'b0;
                done_flag_next = 1'b0;
            end
        endcase
    end

    assign bus.mem_addr      = mem_addr_reg;
    assign bus.mem_ren       = mem_ren_reg;
    assign bus.match_address = match_address_reg;
    assign bus.found         = found_reg;
    assign bus.done_flag     = done_flag_reg;

endmodule

// File: tb/tb_pattern_scanner.sv
// Self-checking bench for pattern_scanner: a first-match search over a bench-held RAM image
// predicts found/address/latency for directed and randomised searches.
module tb_pattern_scanner;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int LAST   = 511;
    localparam int BOUND  = 1100;

    logic clock;
    logic reset;

    pattern_scanner_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pattern_scanner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [DATA_W-1:0] ram [0:LAST];

    int n_tests = 0;
    int n_fail  = 0;

    int obs_lat;
    bit obs_timeout;
    int peak_addr;
    int first_addr;
    bit first_ren;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 1-cycle-latency synchronous RAM model.
    always @(posedge clock) begin
        if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_addr];
    end

    function automatic void ref_search(input logic [DATA_W-1:0] pat, input logic [DATA_W-1:0] msk,
                                       output bit f, output int addr, output int lat);
        f    = 1'b0;
        addr = 0;
        lat  = 2 * (LAST + 1);
        for (int k = 0; k <= LAST; k++) begin
            if (((ram[k] ^ pat) & msk) == '0) begin
                f    = 1'b1;
                addr = k;
                lat  = 2 * k + 2;
                break;
            end
        end
    endfunction

    task automatic fill_ram(input logic [DATA_W-1:0] v);
        for (int k = 0; k <= LAST; k++) ram[k] = v;
    endtask

    // Raise inc_flag; E0 is the next edge. Measures edges from E0 to done_flag.
    task automatic do_search();
        bus.inc_flag = 1'b1;
        @(posedge clock); #1;
        first_addr  = int'(bus.mem_addr);
        first_ren   = bus.mem_ren;
        peak_addr   = int'(bus.mem_addr);
        obs_lat     = 0;
        obs_timeout = 1'b1;
        for (int i = 1; i <= BOUND; i++) begin
            @(posedge clock); #1;
            if (int'(bus.mem_addr) > peak_addr) peak_addr = int'(bus.mem_addr);
            if (bus.done_flag) begin
                obs_lat     = i;
                obs_timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic release_inc();
        bus.inc_flag = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        bus.inc_flag = 1'b0;
        bus.pattern  = '0;
        bus.mask     = '0;
        reset        = 1'b1;
        fill_ram('0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        n_tests++;
        if ({bus.mem_addr, bus.mem_ren, bus.match_address, bus.found, bus.done_flag} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%0d ren=%0b match=%0d found=%0b done=%0b, want all 0",
                     bus.mem_addr, bus.mem_ren, bus.match_address, bus.found, bus.done_flag);
        end
        bus.pattern  = 8'h3C;
        bus.mask     = 8'hFF;
        bus.inc_flag = 1'b1;
        @(posedge clock); #1;
        n_tests++;
        if (bus.mem_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fetch_ren: got %0b want 1", bus.mem_ren);
        end
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.mem_addr, bus.mem_ren, bus.match_address, bus.found, bus.done_flag} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got addr=%0d ren=%0b done=%0b, want all 0",
                     bus.mem_addr, bus.mem_ren, bus.done_flag);
        end
        @(posedge clock); #1;
        reset        = 1'b0;
        bus.inc_flag = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        n_tests++;
        if ({bus.mem_ren, bus.done_flag} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got ren=%0b done=%0b want 0 0", bus.mem_ren, bus.done_flag);
        end
        $display("[TB] reset: checked");
    endtask

    // Launches a search and checks found/address/latency against the reference.
    task automatic run_and_check(input string name, input logic [DATA_W-1:0] pat,
                                 input logic [DATA_W-1:0] msk);
        bit exp_f;
        int exp_a, exp_l;
        bus.pattern = pat;
        bus.mask    = msk;
        ref_search(pat, msk, exp_f, exp_a, exp_l);
        do_search();
        n_tests++;
        if (obs_timeout || obs_lat != exp_l || bus.found !== exp_f ||
            int'(bus.match_address) != exp_a) begin
            n_fail++;
            $display("FAIL %s: got lat=%0d timeout=%0b found=%0b addr=%0d, want lat=%0d found=%0b addr=%0d",
                     name, obs_lat, obs_timeout, bus.found, bus.match_address, exp_l, exp_f, exp_a);
        end
        $display("[TB] %s: pat=%02h mask=%02h lat=%0d found=%0b addr=%0d",
                 name, pat, msk, obs_lat, bus.found, bus.match_address);
    endtask

    task automatic test_hit();
        fill_ram('0);
        ram[5] = 8'hA5;
        run_and_check("hit", 8'hA5, 8'hFF);
        n_tests++;
        if (obs_lat != 12 || int'(bus.match_address) != 5) begin
            n_fail++;
            $display("FAIL hit_directed: got lat=%0d addr=%0d want 12 5", obs_lat, bus.match_address);
        end
        release_inc();
    endtask

    task automatic test_miss();
        fill_ram('0);
        run_and_check("miss", 8'h3C, 8'hFF);
        n_tests++;
        if (peak_addr != LAST || obs_lat != 1024) begin
            n_fail++;
            $display("FAIL miss_peak: got peak=%0d lat=%0d want %0d 1024", peak_addr, obs_lat, LAST);
        end
        release_inc();
    endtask

    task automatic test_boundary();
        fill_ram('0);
        ram[0] = 8'hF0;
        run_and_check("mask_zero", 8'h0F, 8'h00);
        release_inc();
        fill_ram('0);
        ram[LAST] = 8'h7E;
        run_and_check("last_addr", 8'h7E, 8'hFF);
        n_tests++;
        if (bus.found !== 1'b1 || int'(bus.match_address) != LAST) begin
            n_fail++;
            $display("FAIL last_addr_directed: got found=%0b addr=%0d want 1 %0d",
                     bus.found, bus.match_address, LAST);
        end
        release_inc();
    endtask

    task automatic test_handshake();
        logic [ADDR_W-1:0] held_addr;
        logic              held_found;
        bit                bad;
        fill_ram('0);
        ram[3] = 8'h55;
        run_and_check("hs_first", 8'h55, 8'hFF);
        held_addr  = bus.match_address;
        held_found = bus.found;
        bad        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (bus.done_flag !== 1'b1 || bus.mem_ren !== 1'b0 ||
                bus.match_address !== held_addr || bus.found !== held_found) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL hs_hold: got done=%0b ren=%0b addr=%0d, want held 1 0 %0d",
                     bus.done_flag, bus.mem_ren, bus.match_address, held_addr);
        end
        release_inc();
        n_tests++;
        if (bus.done_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_release: got done=%0b want 0", bus.done_flag);
        end
        // An earlier match only becomes visible if the rescan restarts at address 0.
        ram[1] = 8'h55;
        run_and_check("hs_rescan", 8'h55, 8'hFF);
        n_tests++;
        if (first_addr != 0 || first_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_restart: got first_addr=%0d ren=%0b want 0 1", first_addr, first_ren);
        end
        release_inc();
    endtask

    task automatic test_abort();
        bit reached, bad;
        fill_ram('0);
        bus.pattern  = 8'h3C;
        bus.mask     = 8'hFF;
        bus.inc_flag = 1'b1;
        reached      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (int'(bus.mem_addr) == 20) begin
                reached = 1'b1;
                break;
            end
        end
        bus.inc_flag = 1'b0;
        @(posedge clock); #1;
        n_tests++;
        if (!reached || bus.mem_ren !== 1'b0 || bus.done_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next: got reached=%0b ren=%0b done=%0b want 1 0 0",
                     reached, bus.mem_ren, bus.done_flag);
        end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (bus.done_flag !== 1'b0 || bus.mem_ren !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_quiet: got done=%0b ren=%0b want 0 0", bus.done_flag, bus.mem_ren);
        end
        $display("[TB] abort: at addr 20 reached=%0b", reached);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] pat, msk, v;
        int k;
        for (int it = 0; it < 10; it++) begin
            pat = DATA_W'($urandom);
            msk = DATA_W'($urandom);
            if (it % 4 == 3) begin
                msk = 8'hFF;
                for (int a = 0; a <= LAST; a++) begin
                    v = DATA_W'($urandom);
                    if (v == pat) v = ~pat;
                    ram[a] = v;
                end
            end else begin
                for (int a = 0; a <= LAST; a++) ram[a] = DATA_W'($urandom);
                k      = $urandom_range(LAST, 0);
                ram[k] = pat ^ (DATA_W'($urandom) & ~msk);
            end
            run_and_check($sformatf("random%0d", it), pat, msk);
            release_inc();
        end
    endtask

    initial begin
        bus.inc_flag = 1'b0;
        bus.pattern  = '0;
        bus.mask     = '0;
        reset        = 1'b1;
        test_reset();
        test_hit();
        test_miss();
        test_boundary();
        test_handshake();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
